cook_time_counter: RTL and testbench
====================================

Name: cook_time_counter

Overview:
- Time-keeping core of the egg timer. Holds the cook time as four BCD digits (MM:SS).
- Lets the user set the time with the debounced minute and second buttons, and counts it down on a 1 Hz tick strobe.
- Produces the digits for the 7-segment scan stage and the status flags used by the top-level LEDs.
- Runs entirely on the 5 MHz system clock. All slow timing arrives as single-cycle enable strobes, not as derived clocks.

Parameters:
- MAX_MINS, 99: highest settable minute value. Legal range 1..99. A minute increment from MAX_MINS wraps to 0.
- SEC_STEP, 1: seconds added per secs press. Legal values: 1, 5, 10, 15, 30. Seconds wrap to 00 on reaching 60.

Ports:
- clk, input, 1: 5 MHz system clock.
- rst, input, 1: asynchronous, active-high reset.
- tick_1hz, input, 1: single-cycle strobe, once per second.
- cook_time, input, 1: level. High means configuration mode.
- start, input, 1: level. High means run; low means pause.
- mins, input, 1: debounced minute button, level.
- secs, input, 1: debounced second button, level.
- clear, input, 1: single-cycle pulse. Zeroes the time and acknowledges done.
- min_tens, output, 4: BCD, 0..9.
- min_ones, output, 4: BCD, 0..9.
- sec_tens, output, 4: BCD, 0..5.
- sec_ones, output, 4: BCD, 0..9.
- state_o, output, 3: current state encoding. IDLE=0, SET=1, PAUSED=2, RUN=3, DONE=4.
- running, output, 1: high while in RUN.
- done, output, 1: high while in DONE.

Behaviour:
- Reset (asynchronous): state IDLE, all digits 0, running=0, done=0, button edge registers=0.
- Button edges: mins and secs are each registered once. An increment fires on a sampled rising edge (input=1, registered copy=0).
  - The digits show the new value one clk after the edge sample.
  - A held button gives exactly one increment.
- State machine. Evaluated every clk; first matching rule wins.
  - cook_time=1: go to SET from any state. This cancels a run or a pending done.
  - SET:
    - A mins edge adds 1 to the minutes, wrapping MAX_MINS to 0.
    - A secs edge adds SEC_STEP to the seconds, wrapping 60 to 00, with no carry into minutes.
    - Edges on both buttons in the same cycle are both applied.
    - On cook_time=0: go to PAUSED if the time is nonzero, else IDLE.
  - IDLE:
    - The time is 00:00. start and tick_1hz are ignored.
    - Button edges are ignored outside SET.
  - PAUSED:
    - start=1: go to RUN. No decrement happens on the transition cycle, even if tick_1hz is high.
    - clear: zero the time and go to IDLE.
  - RUN:
    - start=0: go to PAUSED. A tick in the same cycle is ignored, because pause has priority.
    - tick_1hz=1: decrement by one second with BCD borrow through sec_ones, sec_tens (5 on borrow), min_ones, min_tens.
    - A tick when the time is 00:01: the time becomes 00:00 and the state becomes DONE on the same edge. done is high starting the next cycle.
    - clear in RUN is ignored.
  - DONE:
    - The digits hold 00:00 and done=1.
    - clear: go to IDLE with done=0 on the next cycle.
    - start is ignored.
- Illegal state encodings recover to IDLE with the time zeroed on the next clk.
- Digits must never hold non-BCD values. sec_tens must never exceed 5.
- running and done are registered decodes of the state; no combinational path from inputs.
- Reset asserted mid-count returns to IDLE/00:00 immediately (asynchronously). Counting needs a fresh configuration after reset.

Test Plan:
- Reset, then cook_time=1, 3 mins presses, 2 secs presses, then cook_time=0 -> digits 0,3,0,2; state PAUSED; done=0.
- Preload 01:00, start=1, one tick -> digits 0,0,5,9 one cycle after the tick; running=1.
- Preload 00:02, start=1, 2 ticks -> 00:00, state DONE, done=1 the cycle after the second tick. A further tick leaves 00:00. clear -> IDLE, done=0.
- Minute wrap: in SET at 99:00, one mins press -> 00:00. With SEC_STEP=15 at 00:45, one secs press -> 00:00 and minutes unchanged.
- Priority: in RUN at 00:10, drop start in the same cycle as a tick -> PAUSED, still 00:10. Raise cook_time mid-run -> SET, time held at its current value.
- Edge behaviour: hold mins high for 1000 cycles -> exactly +1 minute. Assert rst mid-RUN -> IDLE and 00:00 in the same cycle, before the next clk edge.

Source files
------------

// File: rtl/cook_time_counter_if.sv
// Control and display bundle between the egg-timer top level and its time-keeping core.
// The master drives the strobes, levels and buttons. The slave returns the BCD digits and the status.
// clk and rst are kept out of the bundle and stay plain ports.
interface cook_time_counter_if;
  logic       tick_1hz;
  logic       cook_time;
  logic       start;
  logic       mins;
  logic       secs;
  logic       clear;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [2:0] state_o;
  logic       running;
  logic       done;

  modport master (
    output tick_1hz, cook_time, start, mins, secs, clear,
    input  min_tens, min_ones, sec_tens, sec_ones, state_o, running, done
  );

  modport slave (
    input  tick_1hz, cook_time, start, mins, secs, clear,
    output min_tens, min_ones, sec_tens, sec_ones, state_o, running, done
  );
endinterface

// File: rtl/cook_time_counter.sv
// Egg-timer core: the user sets MM:SS in BCD with the buttons, and the time counts down on the 1 Hz strobe.
// Latency: a button edge or a tick shows on the digits one clk later, and running/done follow the state by one clk.
// Backpressure: none. Buttons act only on rising edges, and every other input is sampled on each clk.
module cook_time_counter #(
  parameter int MAX_MINS = 99,
  parameter int SEC_STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  cook_time_counter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SET    = 3'd1,
    S_PAUSED = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] MAX_TENS = 4'(MAX_MINS / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_MINS % 10);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
  logic [3:0] w_min_tens_nxt, w_min_ones_nxt, w_sec_tens_nxt, w_sec_ones_nxt;
  logic [3:0] w_inc_min_tens, w_inc_min_ones;
  logic [3:0] w_add_sec_tens, w_add_sec_ones;
  logic [3:0] w_dec_min_tens, w_dec_min_ones, w_dec_sec_tens, w_dec_sec_ones;
  logic [6:0] w_sec_bin, w_sec_sum;
  logic       r_mins_q, r_secs_q, r_running, r_done;
  logic       w_mins_edge, w_secs_edge, w_time_zero, w_time_one;

  assign w_mins_edge = bus.mins & ~r_mins_q;
  assign w_secs_edge = bus.secs & ~r_secs_q;
  assign w_time_zero = ({r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} == 16'h0000);
  assign w_time_one  = ({r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} == 16'h0001);

  // Minute increment in BCD, wrapping from MAX_MINS back to 00
  always_comb begin
    w_inc_min_tens = r_min_tens;
    w_inc_min_ones = r_min_ones;
    if (r_min_tens == MAX_TENS && r_min_ones == MAX_ONES) begin
      w_inc_min_tens = 4'd0;
      w_inc_min_ones = 4'd0;
    end else if (r_min_ones == 4'd9) begin
      w_inc_min_tens = r_min_tens + 4'd1;
      w_inc_min_ones = 4'd0;
    end else begin
      w_inc_min_ones = r_min_ones + 4'd1;
    end
  end

  // Seconds step: the add is done in binary and converted back, and reaching 60 wraps to 00 with no carry into minutes
  always_comb begin
    w_sec_bin = 7'(r_sec_tens) * 7'd10 + 7'(r_sec_ones);
    w_sec_sum = w_sec_bin + 7'(SEC_STEP);
    if (w_sec_sum >= 7'd60) begin
      w_sec_sum = 7'd0;
    end
    w_add_sec_tens = 4'(w_sec_sum / 7'd10);
    w_add_sec_ones = 4'(w_sec_sum % 7'd10);
  end

  // One-second BCD decrement, with the borrow rippling from sec_ones up to min_tens
  always_comb begin
    w_dec_min_tens = r_min_tens;
    w_dec_min_ones = r_min_ones;
    w_dec_sec_tens = r_sec_tens;
    w_dec_sec_ones = r_sec_ones;
    if (r_sec_ones != 4'd0) begin
      w_dec_sec_ones = r_sec_ones - 4'd1;
    end else begin
      w_dec_sec_ones = 4'd9;
      if (r_sec_tens != 4'd0) begin
        w_dec_sec_tens = r_sec_tens - 4'd1;
      end else begin
        w_dec_sec_tens = 4'd5;
        if (r_min_ones != 4'd0) begin
          w_dec_min_ones = r_min_ones - 4'd1;
        end else begin
          w_dec_min_ones = 4'd9;
          w_dec_min_tens = r_min_tens - 4'd1;
        end
      end
    end
  end

  // Next state and next digits. cook_time overrides everything else, and the time is forced to 00:00 in IDLE and DONE
  always_comb begin
    w_state_nxt    = r_state;
    w_min_tens_nxt = r_min_tens;
    w_min_ones_nxt = r_min_ones;
    w_sec_tens_nxt = r_sec_tens;
    w_sec_ones_nxt = r_sec_ones;
    if (bus.cook_time) begin
      w_state_nxt = S_SET;
      if (r_state == S_SET) begin
        if (w_mins_edge) begin
          w_min_tens_nxt = w_inc_min_tens;
          w_min_ones_nxt = w_inc_min_ones;
        end
        if (w_secs_edge) begin
          w_sec_tens_nxt = w_add_sec_tens;
          w_sec_ones_nxt = w_add_sec_ones;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          {w_min_tens_nxt, w_min_ones_nxt, w_sec_tens_nxt, w_sec_ones_nxt} = 16'h0000;
        end
        S_SET: begin
          w_state_nxt = w_time_zero ? S_IDLE : S_PAUSED;
        end
        S_PAUSED: begin
          if (bus.start) begin
            w_state_nxt = S_RUN;
          end else if (bus.clear) begin
            w_state_nxt = S_IDLE;
            {w_min_tens_nxt, w_min_ones_nxt, w_sec_tens_nxt, w_sec_ones_nxt} = 16'h0000;
          end
        end
        S_RUN: begin
          if (!bus.start) begin
            w_state_nxt = S_PAUSED;
          end else if (bus.tick_1hz) begin
            if (w_time_zero || w_time_one) begin
              w_state_nxt = S_DONE;
              {w_min_tens_nxt, w_min_ones_nxt, w_sec_tens_nxt, w_sec_ones_nxt} = 16'h0000;
            end else begin
              w_min_tens_nxt = w_dec_min_tens;
              w_min_ones_nxt = w_dec_min_ones;
              w_sec_tens_nxt = w_dec_sec_tens;
              w_sec_ones_nxt = w_dec_sec_ones;
            end
          end
        end
        S_DONE: begin
          {w_min_tens_nxt, w_min_ones_nxt, w_sec_tens_nxt, w_sec_ones_nxt} = 16'h0000;
          if (bus.clear) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          {w_min_tens_nxt, w_min_ones_nxt, w_sec_tens_nxt, w_sec_ones_nxt} = 16'h0000;
        end
      endcase
    end
  end

  // State, digits, button history and the registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_min_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_sec_ones <= 4'd0;
      r_mins_q   <= 1'b0;
      r_secs_q   <= 1'b0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_min_tens <= w_min_tens_nxt;
      r_min_ones <= w_min_ones_nxt;
      r_sec_tens <= w_sec_tens_nxt;
      r_sec_ones <= w_sec_ones_nxt;
      r_mins_q   <= bus.mins;
      r_secs_q   <= bus.secs;
      r_running  <= (w_state_nxt == S_RUN);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.min_tens = r_min_tens;
  assign bus.min_ones = r_min_ones;
  assign bus.sec_tens = r_sec_tens;
  assign bus.sec_ones = r_sec_ones;
  assign bus.state_o  = r_state;
  assign bus.running  = r_running;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_cook_time_counter.sv
// Directed bench for cook_time_counter: a default instance and a SEC_STEP=15 instance.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that same point.
module tb_cook_time_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  cook_time_counter_if bus ();
  cook_time_counter_if bus15 ();

  cook_time_counter #(.MAX_MINS(99), .SEC_STEP(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cook_time_counter #(.MAX_MINS(99), .SEC_STEP(15)) u_dut15 (
    .clk (clk),
    .rst (rst),
    .bus (bus15)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tm();
    return {16'h0, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  function automatic logic [31:0] tm15();
    return {16'h0, bus15.min_tens, bus15.min_ones, bus15.sec_tens, bus15.sec_ones};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mins(input int n);
    for (int i = 0; i < n; i++) begin
      bus.mins = 1'b1; step();
      bus.mins = 1'b0; step();
    end
  endtask

  task automatic press_secs(input int n);
    for (int i = 0; i < n; i++) begin
      bus.secs = 1'b1; step();
      bus.secs = 1'b0; step();
    end
  endtask

  task automatic configure(input int m, input int s);
    bus.cook_time = 1'b1; step();
    press_mins(m);
    press_secs(s);
    bus.cook_time = 1'b0; step();
  endtask

  task automatic tick();
    bus.tick_1hz = 1'b1; step();
    bus.tick_1hz = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1; step();
    bus.clear = 1'b0;
  endtask

  initial begin
    {bus.tick_1hz, bus.cook_time, bus.start, bus.mins, bus.secs, bus.clear} = 6'b0;
    {bus15.tick_1hz, bus15.cook_time, bus15.start, bus15.mins, bus15.secs, bus15.clear} = 6'b0;
    step(); step();
    check("reset_state", 32'(bus.state_o), 0);
    check("reset_time", tm(), 32'h0000);
    check("reset_running", 32'(bus.running), 0);
    check("reset_done", 32'(bus.done), 0);
    rst = 1'b0;
    step();

    // Buttons and start are ignored while IDLE
    press_mins(1);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    check("idle_ignore_state", 32'(bus.state_o), 0);
    check("idle_ignore_time", tm(), 32'h0000);

    // Set 03:02, then leave configuration mode
    configure(3, 2);
    check("cfg_time", tm(), 32'h0302);
    check("cfg_state", 32'(bus.state_o), 2);
    check("cfg_done", 32'(bus.done), 0);
    pulse_clear();
    check("paused_clear_state", 32'(bus.state_o), 0);
    check("paused_clear_time", tm(), 32'h0000);

    // Both buttons in the same cycle are both applied
    bus.cook_time = 1'b1; step();
    bus.mins = 1'b1; bus.secs = 1'b1; step();
    check("both_edges", tm(), 32'h0101);
    bus.mins = 1'b0; bus.secs = 1'b0; step();
    bus.cook_time = 1'b0; step();
    pulse_clear();

    // 01:00 with one tick borrows down to 00:59
    configure(1, 0);
    bus.start = 1'b1; step();
    check("run_enter_state", 32'(bus.state_o), 3);
    check("run_enter_time", tm(), 32'h0100);
    check("run_running", 32'(bus.running), 1);
    tick();
    check("borrow_time", tm(), 32'h0059);
    check("borrow_running", 32'(bus.running), 1);
    pulse_clear();
    check("run_clear_ignored", tm(), 32'h0059);
    bus.start = 1'b0; step();
    pulse_clear();

    // 00:02 counts down to DONE
    configure(0, 2);
    bus.start = 1'b1; step();
    tick(); step();
    check("cd_one", tm(), 32'h0001);
    tick();
    check("cd_zero", tm(), 32'h0000);
    check("cd_state", 32'(bus.state_o), 4);
    check("cd_done", 32'(bus.done), 1);
    check("cd_running", 32'(bus.running), 0);
    tick();
    check("done_tick_time", tm(), 32'h0000);
    check("done_tick_state", 32'(bus.state_o), 4);
    pulse_clear();
    check("done_clear_state", 32'(bus.state_o), 0);
    check("done_clear_done", 32'(bus.done), 0);
    bus.start = 1'b0; step();

    // Pause wins over a simultaneous tick. cook_time cancels a run and keeps the time
    configure(0, 10);
    bus.start = 1'b1; step();
    bus.start = 1'b0; bus.tick_1hz = 1'b1; step(); bus.tick_1hz = 1'b0;
    check("pause_prio_state", 32'(bus.state_o), 2);
    check("pause_prio_time", tm(), 32'h0010);
    bus.start = 1'b1; step();
    tick();
    check("resume_tick", tm(), 32'h0009);
    bus.cook_time = 1'b1; step();
    check("cancel_state", 32'(bus.state_o), 1);
    check("cancel_time", tm(), 32'h0009);
    check("cancel_running", 32'(bus.running), 0);
    bus.start = 1'b0;
    press_mins(99);
    check("min_99", tm(), 32'h9909);
    press_mins(1);
    check("min_wrap", tm(), 32'h0009);
    bus.cook_time = 1'b0; step();
    pulse_clear();

    // A held button gives exactly one increment
    bus.cook_time = 1'b1; step();
    bus.mins = 1'b1;
    repeat (1000) step();
    bus.mins = 1'b0; step();
    check("hold_once", tm(), 32'h0100);
    bus.cook_time = 1'b0; step();

    // Asynchronous reset mid-run
    bus.start = 1'b1; step();
    tick();
    check("pre_rst_time", tm(), 32'h0059);
    rst = 1'b1;
    #1;
    check("async_rst_state", 32'(bus.state_o), 0);
    check("async_rst_time", tm(), 32'h0000);
    check("async_rst_running", 32'(bus.running), 0);
    #2 rst = 1'b0;
    step();
    tick();
    check("post_rst_idle", 32'(bus.state_o), 0);
    check("post_rst_time", tm(), 32'h0000);
    bus.start = 1'b0;

    // SEC_STEP=15: seconds wrap from 45 to 00 with no carry into minutes
    bus15.cook_time = 1'b1; step();
    for (int i = 0; i < 2; i++) begin
      bus15.mins = 1'b1; step(); bus15.mins = 1'b0; step();
    end
    for (int i = 0; i < 3; i++) begin
      bus15.secs = 1'b1; step(); bus15.secs = 1'b0; step();
    end
    check("s15_045", tm15(), 32'h0245);
    bus15.secs = 1'b1; step(); bus15.secs = 1'b0; step();
    check("s15_wrap", tm15(), 32'h0200);
    bus15.cook_time = 1'b0; step();
    check("s15_paused", 32'(bus15.state_o), 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
